// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-to-L2 line arbiter: FSM states, grant side,
// the latched request record and a line-alignment helper.
package cache_arbiter_pkg;

    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_LINE_W    = 256;
    localparam int LINE_OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RECOVER
    } arb_state_t;

    typedef enum logic {
        grant_i,
        grant_d
    } arb_grant_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] address;
        logic [ARB_LINE_W-1:0] wdata;
        logic                  write;
    } arb_req_t;

    // Clears the byte-within-line offset so L2 always sees a line address.
    function automatic logic [ARB_ADDR_W-1:0] line_align(input logic [ARB_ADDR_W-1:0] addr);
        return {addr[ARB_ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter putting the icache and dcache line-miss ports onto a
// single L2 port, one line transaction at a time. The winning request is
// latched at grant so L2 sees stable signals regardless of the live inputs.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              busy
);

    arb_state_t state_q, state_next;
    arb_grant_t last_grant_q, last_grant_next;
    arb_req_t   req_q, req_next;

    logic d_pending;
    logic pick_d;

    // On a tie the side that did not win last time gets the grant.
    assign d_pending = d_read | d_write;
    assign pick_d    = d_pending & (~i_read | (last_grant_q == grant_i));

    // State, fairness pointer and latched request; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= grant_i;
            req_q        <= '0;
        end else begin
            state_q      <= state_next;
            last_grant_q <= last_grant_next;
            req_q        <= req_next;
        end
    end

    // Next-state, request latching and all outputs; L2 is driven only from req_q.
    always_comb begin
        state_next      = state_q;
        last_grant_next = last_grant_q;
        req_next        = req_q;
        l2_read         = 1'b0;
        l2_write        = 1'b0;
        l2_address      = '0;
        l2_wdata        = '0;
        i_rdata         = '0;
        i_resp          = 1'b0;
        d_rdata         = '0;
        d_resp          = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    req_next.address = line_align(d_address);
                    req_next.wdata   = d_wdata;
                    req_next.write   = d_write;
                    last_grant_next  = grant_d;
                    state_next       = SERVE_D;
                end else if (i_read) begin
                    req_next.address = line_align(i_address);
                    req_next.wdata   = '0;
                    req_next.write   = 1'b0;
                    last_grant_next  = grant_i;
                    state_next       = SERVE_I;
                end
            end
            SERVE_I: begin
                l2_read    = 1'b1;
                l2_address = req_q.address;
                i_rdata    = l2_rdata;
                i_resp     = l2_resp;
                if (l2_resp) begin
                    state_next = RECOVER;
                end
            end
            SERVE_D: begin
                l2_read    = ~req_q.write;
                l2_write   = req_q.write;
                l2_address = req_q.address;
                l2_wdata   = req_q.wdata;
                d_rdata    = l2_rdata;
                d_resp     = l2_resp;
                if (l2_resp) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // A dcache asking for read and write at once is served as a write but is a protocol error.
    rw_conflict: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE && pick_d) |-> !(d_read && d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expected L2 requests and
// cache responses into queues; a negedge monitor pops and compares them.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_WD = {8{32'hDEAD_BEEF}};
    localparam logic [LINE_W-1:0] PAT_11 = {32{8'h11}};
    localparam logic [LINE_W-1:0] PAT_22 = {32{8'h22}};
    localparam logic [LINE_W-1:0] PAT_33 = {32{8'h33}};
    localparam logic [LINE_W-1:0] PAT_44 = {32{8'h44}};
    localparam logic [LINE_W-1:0] PAT_55 = {32{8'h55}};
    localparam logic [LINE_W-1:0] PAT_66 = {32{8'h66}};
    localparam logic [LINE_W-1:0] PAT_77 = {32{8'h77}};

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              i_read    = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read    = 1'b0;
    logic              d_write   = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [LINE_W-1:0] d_wdata   = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata  = '0;
    logic              l2_resp   = 1'b0;
    logic              busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } l2_exp_t;

    typedef struct {
        logic              is_d;
        logic [LINE_W-1:0] rdata;
    } resp_exp_t;

    l2_exp_t   l2_q[$];
    resp_exp_t resp_q[$];

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_rdata   (l2_rdata),
        .l2_resp    (l2_resp),
        .busy       (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop if the run somehow never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [ADDR_W-1:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [ADDR_W-1:0] da, input logic [LINE_W-1:0] dwd);
        i_read    = ir;
        i_address = ia;
        d_read    = dr;
        d_write   = dw;
        d_address = da;
        d_wdata   = dwd;
    endtask

    task automatic expectL2(input logic w, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
        l2_exp_t e;
        e.write = w;
        e.addr  = a;
        e.wdata = wd;
        l2_q.push_back(e);
    endtask

    task automatic expectResp(input logic is_d, input logic [LINE_W-1:0] data);
        resp_exp_t r;
        r.is_d  = is_d;
        r.rdata = data;
        resp_q.push_back(r);
    endtask

    task automatic resetDut();
        rst_n   = 1'b0;
        l2_resp = 1'b0;
        l2_rdata = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
    endtask

    // Behaves as L2: waits (bounded) for a request, then answers after 'delay' cycles.
    task automatic l2Answer(input int delay, input logic [LINE_W-1:0] data);
        int waited = 0;
        while (!(l2_read || l2_write) && waited < 20) begin
            waitCycle();
            waited++;
        end
        checkOutput("l2_request_seen", LINE_W'(l2_read || l2_write), LINE_W'(1));
        if (l2_read || l2_write) begin
            repeat (delay) waitCycle();
            l2_rdata = data;
            l2_resp  = 1'b1;
            waitCycle();
            l2_resp  = 1'b0;
            l2_rdata = '0;
        end
    endtask

    logic      prev_req = 1'b0;
    l2_exp_t   mon_l2;
    resp_exp_t mon_resp;

    // Monitor: checks every new L2 request and every cache response pulse against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if ((l2_read || l2_write) && !prev_req) begin
                total++;
                if (l2_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL l2_unexpected: got rd=%0b wr=%0b addr=%h required no request",
                             l2_read, l2_write, l2_address);
                end else begin
                    mon_l2 = l2_q.pop_front();
                    if (l2_write !== mon_l2.write || l2_read !== !mon_l2.write ||
                        l2_address !== mon_l2.addr || (mon_l2.write && l2_wdata !== mon_l2.wdata)) begin
                        bad++;
                        $display("[TB] FAIL l2_request: got wr=%0b addr=%h wdata=%h required wr=%0b addr=%h wdata=%h",
                                 l2_write, l2_address, l2_wdata, mon_l2.write, mon_l2.addr, mon_l2.wdata);
                    end
                end
            end
            prev_req = l2_read || l2_write;

            if (i_resp || d_resp) begin
                total++;
                if (resp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL resp_unexpected: got i_resp=%0b d_resp=%0b required none",
                             i_resp, d_resp);
                end else begin
                    mon_resp = resp_q.pop_front();
                    if (mon_resp.is_d) begin
                        if (!d_resp || i_resp || d_rdata !== mon_resp.rdata || i_rdata !== '0) begin
                            bad++;
                            $display("[TB] FAIL d_response: got d_resp=%0b i_resp=%0b d_rdata=%h required d_resp=1 i_resp=0 d_rdata=%h",
                                     d_resp, i_resp, d_rdata, mon_resp.rdata);
                        end
                    end else begin
                        if (!i_resp || d_resp || i_rdata !== mon_resp.rdata || d_rdata !== '0) begin
                            bad++;
                            $display("[TB] FAIL i_response: got i_resp=%0b d_resp=%0b i_rdata=%h required i_resp=1 d_resp=0 i_rdata=%h",
                                     i_resp, d_resp, i_rdata, mon_resp.rdata);
                        end
                    end
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        logic [7:0]        b;
        logic [LINE_W-1:0] data;

        // Reset values
        repeat (2) waitCycle();
        checkOutput("rst_busy",     LINE_W'(busy),       LINE_W'(0));
        checkOutput("rst_l2_read",  LINE_W'(l2_read),    LINE_W'(0));
        checkOutput("rst_l2_write", LINE_W'(l2_write),   LINE_W'(0));
        checkOutput("rst_l2_addr",  LINE_W'(l2_address), LINE_W'(0));
        checkOutput("rst_l2_wdata", l2_wdata,            LINE_W'(0));
        checkOutput("rst_resps",    LINE_W'({i_resp, d_resp}), LINE_W'(0));
        rst_n = 1'b1;
        waitCycle();

        // Lone icache read, unaligned address
        $display("[TB] lone icache read");
        expectL2(1'b0, 32'h0000_1000, '0);
        expectResp(1'b0, PAT_A5);
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, '0, '0);
        waitCycle();
        checkOutput("t1_l2_read", LINE_W'(l2_read),    LINE_W'(1));
        checkOutput("t1_l2_addr", LINE_W'(l2_address), LINE_W'(32'h0000_1000));
        checkOutput("t1_busy",    LINE_W'(busy),       LINE_W'(1));
        l2Answer(5, PAT_A5);
        checkOutput("t1_recover_busy", LINE_W'(busy),    LINE_W'(1));
        checkOutput("t1_recover_read", LINE_W'(l2_read), LINE_W'(0));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        waitCycle();
        checkOutput("t1_idle_busy", LINE_W'(busy), LINE_W'(0));

        // Simultaneous after reset: dcache write first, then icache 3 cycles later
        $display("[TB] simultaneous icache read and dcache write");
        resetDut();
        expectL2(1'b1, 32'h2000_0040, PAT_WD);
        expectResp(1'b1, PAT_11);
        expectL2(1'b0, 32'h3000_0000, '0);
        expectResp(1'b0, PAT_22);
        applyStimulus(1'b1, 32'h3000_0010, 1'b0, 1'b1, 32'h2000_0047, PAT_WD);
        waitCycle();
        checkOutput("t2_l2_write", LINE_W'(l2_write), LINE_W'(1));
        checkOutput("t2_l2_read",  LINE_W'(l2_read),  LINE_W'(0));
        checkOutput("t2_l2_wdata", l2_wdata,          PAT_WD);
        l2Answer(2, PAT_11);
        applyStimulus(1'b1, 32'h3000_0010, 1'b0, 1'b0, '0, '0);
        checkOutput("t2_turn_m1", LINE_W'(l2_read || l2_write), LINE_W'(0));
        waitCycle();
        checkOutput("t2_turn_m2", LINE_W'(l2_read || l2_write), LINE_W'(0));
        waitCycle();
        checkOutput("t2_turn_m3", LINE_W'(l2_read), LINE_W'(1));
        l2Answer(1, PAT_22);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        waitCycle();

        // Both caches requesting continuously: D, I, D, I, D, I
        $display("[TB] continuous contention");
        resetDut();
        for (int k = 0; k < 6; k++) begin
            b    = 8'h30 + 8'(k);
            data = {32{b}};
            if (k % 2 == 0) begin
                expectL2(1'b0, 32'h0000_0400, '0);
                expectResp(1'b1, data);
            end else begin
                expectL2(1'b0, 32'h0000_0500, '0);
                expectResp(1'b0, data);
            end
        end
        applyStimulus(1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0400, '0);
        for (int k = 0; k < 6; k++) begin
            b    = 8'h30 + 8'(k);
            data = {32{b}};
            l2Answer(k, data);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) waitCycle();

        // Live address change while SERVE_D waits
        $display("[TB] address held during service");
        resetDut();
        expectL2(1'b0, 32'h0000_0100, '0);
        expectResp(1'b1, PAT_33);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_0100, '0);
        waitCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_0200, '0);
        waitCycle();
        checkOutput("t4_addr_hold_a", LINE_W'(l2_address), LINE_W'(32'h0000_0100));
        repeat (2) waitCycle();
        checkOutput("t4_addr_hold_b", LINE_W'(l2_address), LINE_W'(32'h0000_0100));
        l2Answer(0, PAT_33);
        checkOutput("t4_recover_addr", LINE_W'(l2_address), LINE_W'(0));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        waitCycle();

        // Reset two cycles into SERVE_I, then pending dcache wins
        $display("[TB] mid-transaction reset");
        resetDut();
        expectL2(1'b0, 32'h0000_0600, '0);
        applyStimulus(1'b1, 32'h0000_0600, 1'b0, 1'b0, '0, '0);
        repeat (2) waitCycle();
        applyStimulus(1'b1, 32'h0000_0600, 1'b1, 1'b0, 32'h0000_0700, '0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy",    LINE_W'(busy),       LINE_W'(0));
        checkOutput("t5_rst_l2_read", LINE_W'(l2_read),    LINE_W'(0));
        checkOutput("t5_rst_l2_addr", LINE_W'(l2_address), LINE_W'(0));
        checkOutput("t5_rst_resp",    LINE_W'({i_resp, d_resp}), LINE_W'(0));
        waitCycle();
        rst_n = 1'b1;
        expectL2(1'b0, 32'h0000_0700, '0);
        expectResp(1'b1, PAT_44);
        waitCycle();
        checkOutput("t5_d_first", LINE_W'(l2_address), LINE_W'(32'h0000_0700));
        l2Answer(1, PAT_44);
        applyStimulus(1'b1, 32'h0000_0600, 1'b0, 1'b0, '0, '0);
        expectL2(1'b0, 32'h0000_0600, '0);
        expectResp(1'b0, PAT_55);
        l2Answer(1, PAT_55);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        waitCycle();

        // Spurious l2_resp in IDLE, at grant, and in RECOVER
        $display("[TB] spurious l2_resp");
        resetDut();
        l2_rdata = PAT_66;
        l2_resp  = 1'b1;
        #1;
        checkOutput("t6_idle_resp",  LINE_W'({i_resp, d_resp}), LINE_W'(0));
        checkOutput("t6_idle_rdata", i_rdata, LINE_W'(0));
        waitCycle();
        l2_resp  = 1'b0;
        l2_rdata = '0;
        checkOutput("t6_idle_busy", LINE_W'(busy), LINE_W'(0));

        expectL2(1'b0, 32'h0000_0800, '0);
        expectResp(1'b0, PAT_77);
        applyStimulus(1'b1, 32'h0000_0800, 1'b0, 1'b0, '0, '0);
        l2_rdata = PAT_66;
        l2_resp  = 1'b1;
        #1;
        checkOutput("t6_grant_resp", LINE_W'(i_resp), LINE_W'(0));
        waitCycle();
        l2_resp  = 1'b0;
        l2_rdata = '0;
        checkOutput("t6_grant_read", LINE_W'(l2_read), LINE_W'(1));
        waitCycle();
        checkOutput("t6_grant_still_busy", LINE_W'(busy), LINE_W'(1));
        l2Answer(1, PAT_77);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        l2_rdata = PAT_66;
        l2_resp  = 1'b1;
        #1;
        checkOutput("t6_recover_resp",  LINE_W'({i_resp, d_resp}), LINE_W'(0));
        checkOutput("t6_recover_rdata", i_rdata, LINE_W'(0));
        waitCycle();
        l2_resp  = 1'b0;
        l2_rdata = '0;
        checkOutput("t6_recover_to_idle", LINE_W'(busy), LINE_W'(0));
        checkOutput("t6_idle_no_req", LINE_W'(l2_read || l2_write), LINE_W'(0));
        repeat (2) waitCycle();

        checkOutput("l2_queue_drained",   LINE_W'(l2_q.size()),   LINE_W'(0));
        checkOutput("resp_queue_drained", LINE_W'(resp_q.size()), LINE_W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
